calc_operand_entry: RTL and testbench
=====================================

// Module: calc_operand_entry
// PURPOSE
//  Operand/opcode entry sequencer for the mini calculator. Debounces two push
//  buttons and captures the 12-bit switch bank into r0, r1 and the 4-bit
//  opcode rs, one per ENTER press. Drives the 3-bit display-select code bt so
//  the display stage shows the register being committed, then the ALU result.
//  Sits directly upstream of the calculator top level and feeds its r0, r1,
//  rs and bt inputs.
// PARAMETERS
//  DEB_CYCLES  250000  consecutive stable cycles needed to accept a button level change
//  CNT_W       18      debounce counter width; must satisfy 2**CNT_W > DEB_CYCLES
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  sw            in   12  switch bank: operand value, or opcode in sw[3:0]
//  btn_enter     in   1   raw ENTER push button, active-high, asynchronous
//  btn_clear     in   1   raw CLEAR push button, active-high, asynchronous
//  r0            out  12  committed operand A
//  r1            out  12  committed operand B
//  rs            out  4   committed ALU opcode
//  bt            out  3   display select: 001=r0, 010=r1, 100=rs, 000=ALU result
//  stage         out  2   FSM state: 0=S_A, 1=S_B, 2=S_OP, 3=S_RES
//  result_valid  out  1   high only in S_RES
// BEHAVIOUR
//  Reset (rst_n low, asynchronous): r0=0, r1=0, rs=0, stage=S_A, bt=001,
//   result_valid=0. Synchronizers, debounced levels and counters all clear to 0.
//   Reset mid-sequence discards all partial entry.
//  Input conditioning, identical for each button:
//   - 2-flop synchronizer.
//   - Counter runs while the synchronized level differs from the debounced level.
//   - Counter clears to 0 the first cycle the levels match again.
//   - When the counter reaches DEB_CYCLES-1 while still differing, the debounced
//     level flips and the counter clears.
//   - A one-cycle pulse (enter_p / clear_p) fires on each 0->1 flip of the
//     debounced level. A 1->0 flip gives no pulse.
//   - Holding a button gives exactly one pulse. A glitch shorter than
//     DEB_CYCLES cycles gives none.
//  Latency: a clean press held long enough has its pulse high 2+DEB_CYCLES cycles
//   after the raw edge. Registers, stage and bt update on the clock edge that
//   samples the pulse.
//  FSM on enter_p:
//   - S_A: r0<=sw, go to S_B.
//   - S_B: r1<=sw, go to S_OP.
//   - S_OP: rs<=sw[3:0], go to S_RES. sw[11:4] is ignored.
//   - S_RES: go to S_A. r0, r1 and rs are kept.
//  FSM on clear_p, in any state: r0=r1=rs=0, go to S_A.
//  Simultaneous enter_p and clear_p: clear wins and no load occurs.
//  bt decodes from stage only: S_A=001, S_B=010, S_OP=100, S_RES=000.
//   It is registered and glitch-free.
//  rs is passed unchecked: 7 and 8-15 reach the ALU as entered.
//  sw is sampled directly at the load edge and needs no synchronizer; switches
//   are quasi-static.
//  Outputs hold their value between loads. No combinational path from any input
//   to any output.
// TESTING (bench uses DEB_CYCLES=4)
//  1. rst_n low mid-run, then released -> all outputs at reset values, stage=0,
//     bt=001 immediately on assertion.
//  2. sw=11 ENTER, sw=8 ENTER, sw=0 ENTER, each press held 10 cycles -> r0=11,
//     r1=8, rs=0, stage=3, bt=000, result_valid=1. Each pulse is exactly 6 cycles
//     after its raw edge.
//  3. ENTER toggled with a 2-cycle high glitch, then held 30 cycles -> exactly one
//     load, and stage advances by 1 only.
//  4. In S_OP with r0=r1=5, press CLEAR -> r0=r1=rs=0, stage=0, bt=001.
//  5. Raw ENTER and CLEAR rise in the same cycle in S_B -> r1 stays 0, stage=0.
//  6. In S_RES, ENTER -> stage=0, r0/r1/rs unchanged. sw=12'hFFF ENTER in S_OP ->
//     rs=4'hF.

Source files
------------

// File: rtl/calc_operand_entry.sv
//==============================================================================
// Module   : calc_operand_entry
// Purpose  : Debounced ENTER/CLEAR sequencer that captures r0, r1 and the ALU
//            opcode from the switch bank and drives the display select code.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module calc_operand_entry #(
    parameter int DEB_CYCLES = 250000,
    parameter int CNT_W      = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] sw,
    input  logic        btn_enter,
    input  logic        btn_clear,
    output logic [11:0] r0,
    output logic [11:0] r1,
    output logic [3:0]  rs,
    output logic [2:0]  bt,
    output logic [1:0]  stage,
    output logic        result_valid
);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RES = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [1:0] w_btn_raw;
    logic [1:0] w_pulse;
    logic       w_enter_p;
    logic       w_clear_p;

    assign w_btn_raw = {btn_clear, btn_enter};
    assign w_enter_p = w_pulse[0];
    assign w_clear_p = w_pulse[1];

    // Index 0 conditions ENTER, index 1 conditions CLEAR.
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        logic             r_sync1;
        logic             r_sync2;
        logic             r_level;
        logic             r_pulse;
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_level <= 1'b0;
                r_pulse <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_btn_raw[gi];
                r_sync2 <= r_sync1;
                r_pulse <= 1'b0;
                if (r_sync2 != r_level) begin
                    if (r_cnt == C_CNT_MAX) begin
                        r_level <= r_sync2;
                        r_cnt   <= '0;
                        r_pulse <= r_sync2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_pulse[gi] = r_pulse;
    end

    state_t     r_state;
    state_t     w_state_next;
    logic       w_load_a;
    logic       w_load_b;
    logic       w_load_op;
    logic       w_clr;
    logic [2:0] w_bt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // CLEAR has priority so a simultaneous ENTER never loads anything.
    always_comb begin
        w_state_next = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_load_op    = 1'b0;
        w_clr        = 1'b0;
        if (w_clear_p) begin
            w_clr        = 1'b1;
            w_state_next = S_A;
        end else if (w_enter_p) begin
            case (r_state)
                S_A: begin
                    w_load_a     = 1'b1;
                    w_state_next = S_B;
                end
                S_B: begin
                    w_load_b     = 1'b1;
                    w_state_next = S_OP;
                end
                S_OP: begin
                    w_load_op    = 1'b1;
                    w_state_next = S_RES;
                end
                default: w_state_next = S_A;
            endcase
        end
    end

    always_comb begin
        w_bt_next = 3'b000;
        case (w_state_next)
            S_A:     w_bt_next = 3'b001;
            S_B:     w_bt_next = 3'b010;
            S_OP:    w_bt_next = 3'b100;
            default: w_bt_next = 3'b000;
        endcase
    end

    // bt and result_valid are registered from the next state so they track stage glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0           <= '0;
            r1           <= '0;
            rs           <= '0;
            bt           <= 3'b001;
            result_valid <= 1'b0;
        end else begin
            if (w_clr) begin
                r0 <= '0;
                r1 <= '0;
                rs <= '0;
            end else begin
                if (w_load_a)  r0 <= sw;
                if (w_load_b)  r1 <= sw;
                if (w_load_op) rs <= sw[3:0];
            end
            bt           <= w_bt_next;
            result_valid <= (w_state_next == S_RES);
        end
    end

    assign stage = r_state;

endmodule

`default_nettype wire

// File: tb/tb_calc_operand_entry.sv
//==============================================================================
// Module   : tb_calc_operand_entry
// Purpose  : Scoreboard bench for the operand entry sequencer (DEB_CYCLES=4).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_calc_operand_entry;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] sw = '0;
    logic        btn_enter = 1'b0;
    logic        btn_clear = 1'b0;
    logic [11:0] r0;
    logic [11:0] r1;
    logic [3:0]  rs;
    logic [2:0]  bt;
    logic [1:0]  stage;
    logic        result_valid;

    calc_operand_entry #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .btn_enter    (btn_enter),
        .btn_clear    (btn_clear),
        .r0           (r0),
        .r1           (r1),
        .rs           (rs),
        .bt           (bt),
        .stage        (stage),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] r0;
        logic [11:0] r1;
        logic [3:0]  rs;
        logic [1:0]  st;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] bt_of(input logic [1:0] st);
        case (st)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".r0"}, 32'(r0), 32'(e.r0));
        chk({tag, ".r1"}, 32'(r1), 32'(e.r1));
        chk({tag, ".rs"}, 32'(rs), 32'(e.rs));
        chk({tag, ".stage"}, 32'(stage), 32'(e.st));
        chk({tag, ".bt"}, 32'(bt), 32'(bt_of(e.st)));
        chk({tag, ".rv"}, 32'(result_valid), 32'(e.st == 2'd3));
    endtask

    // Drive a press right after a clock edge; the DUT must act on the 7th edge after it.
    task automatic press(input string tag, input logic ent, input logic clr,
                         input logic [11:0] swv, input int hold);
        exp_t e;
        exp_t got_e;
        logic [1:0] old_st;
        sw        = swv;
        btn_enter = ent;
        btn_clear = clr;
        old_st    = m.st;
        e         = m;
        if (clr) begin
            e.r0 = '0; e.r1 = '0; e.rs = '0; e.st = 2'd0;
        end else if (ent) begin
            case (m.st)
                2'd0: begin e.r0 = swv;       e.st = 2'd1; end
                2'd1: begin e.r1 = swv;       e.st = 2'd2; end
                2'd2: begin e.rs = swv[3:0];  e.st = 2'd3; end
                default: e.st = 2'd0;
            endcase
        end
        sb_q.push_back(e);
        m = e;
        repeat (DEB + 2) @(posedge clk);
        #1 chk({tag, ".early"}, 32'(stage), 32'(old_st));
        @(posedge clk);
        #1;
        got_e = sb_q.pop_front();
        check_all(tag, got_e);
        repeat (hold - (DEB + 3)) @(posedge clk);
        #1;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (DEB + 6) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        m = '{r0: 12'd0, r1: 12'd0, rs: 4'd0, st: 2'd0};
        repeat (3) @(posedge clk);
        #1 check_all("reset", m);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-run: take a value, then assert asynchronously between edges.
        press("pre", 1'b1, 1'b0, 12'd7, 10);
        #2 rst_n = 1'b0;
        m = '{r0: 12'd0, r1: 12'd0, rs: 4'd0, st: 2'd0};
        #1 check_all("async_rst", m);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        press("op_a", 1'b1, 1'b0, 12'd11, 10);
        press("op_b", 1'b1, 1'b0, 12'd8, 10);
        press("opc",  1'b1, 1'b0, 12'd0, 10);
        press("res",  1'b1, 1'b0, 12'h123, 10);

        // A 2-cycle glitch must be rejected; the following long hold loads once.
        sw = 12'd5;
        btn_enter = 1'b1;
        repeat (2) @(posedge clk);
        #1 btn_enter = 1'b0;
        repeat (12) @(posedge clk);
        #1 chk("glitch.stage", 32'(stage), 32'(m.st));
        press("hold30", 1'b1, 1'b0, 12'd5, 30);
        press("b5", 1'b1, 1'b0, 12'd5, 10);
        chk("b5.in_sop", 32'(stage), 32'd2);
        press("clear", 1'b0, 1'b1, 12'hABC, 10);

        press("a9", 1'b1, 1'b0, 12'd9, 10);
        press("both", 1'b1, 1'b1, 12'h777, 10);

        press("a1", 1'b1, 1'b0, 12'd1, 10);
        press("b2", 1'b1, 1'b0, 12'd2, 10);
        press("opF", 1'b1, 1'b0, 12'hFFF, 10);
        chk("opF.queue_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
